// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE stream sink realigner.
//   ctrl_sink_realign_t  : realign enable, byte offset, line length in words
//   flags_sink_realign_t : line_done pulse, busy level
//   sink_realign_state_e : realigner FSM states
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_DW      = 32;
  localparam int unsigned SINK_REALIGN_OFFS_W = $clog2(HWPE_STREAM_DW / 8);

  typedef struct packed {
    logic                           realign;
    logic [SINK_REALIGN_OFFS_W-1:0] offset;
    logic [15:0]                    line_length;
  } ctrl_sink_realign_t;

  typedef struct packed {
    logic line_done;
    logic busy;
  } flags_sink_realign_t;

  typedef enum logic [1:0] {
    SINK_REALIGN_FIRST,
    SINK_REALIGN_MIDDLE,
    SINK_REALIGN_FLUSH
  } sink_realign_state_e;

endpackage

// File: rtl/hwpe_stream_intf.sv
// Valid/ready stream bundle with byte strobes.
//   sink   : consumer view (data/strb/valid in, ready out)
//   source : producer view (data/strb/valid out, ready in)
interface hwpe_stream_intf #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport sink   (input  valid, data, strb, output ready);
  modport source (output valid, data, strb, input  ready);
endinterface

// File: rtl/hwpe_stream_sink_realign.sv
// Store-side realigner: shifts a line of word-aligned beats by k bytes and adds
// byte strobes so the line can be stored at a misaligned TCDM address. With
// realign enabled and k!=0, N input beats become N+1 output beats (a trailing
// flush beat carries the bytes spilling out of the last word).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear, same effect as reset
//   ctrl_i        : realign, offset, line_length (sampled at first word of a line)
//   flags_o       : line_done (pulse with final output beat), busy
//   stream_i      : aligned input stream (strb ignored)
//   stream_o      : realigned output stream with byte strobes
module hwpe_stream_sink_realign
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = HWPE_STREAM_DW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  ctrl_sink_realign_t  ctrl_i,
  output flags_sink_realign_t flags_o,
  hwpe_stream_intf.sink       stream_i,
  hwpe_stream_intf.source     stream_o
);

  localparam int unsigned B      = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(B);
  localparam int unsigned SH_W   = OFFS_W + 4;

  sink_realign_state_e   r_state, w_state_d;
  logic [15:0]           r_word_cnt;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [OFFS_W-1:0]     r_offs;
  logic [15:0]           r_len;
  logic                  r_realign;

  logic [OFFS_W-1:0]     w_k;
  logic                  w_realign;
  logic                  w_active;
  logic [15:0]           w_len;
  logic [SH_W-1:0]       w_lsh;
  logic [SH_W-1:0]       w_rsh;
  logic [DATA_WIDTH-1:0] w_shl;
  logic [DATA_WIDTH-1:0] w_shr;
  logic [B-1:0]          w_strb_first;
  logic                  w_in_hs;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic [B-1:0]          w_out_strb;
  logic                  w_out_valid;
  logic                  w_in_ready;
  logic                  w_line_done;
  logic                  w_unused_strb;

  assign w_unused_strb = ^stream_i.strb;

  // In FIRST the line has not started yet, so control is taken live from
  // ctrl_i; afterwards the values latched at the first handshake are used.
  assign w_k       = (r_state == SINK_REALIGN_FIRST) ? OFFS_W'(ctrl_i.offset) : r_offs;
  assign w_realign = (r_state == SINK_REALIGN_FIRST) ? ctrl_i.realign : r_realign;
  assign w_active  = w_realign && (w_k != '0);
  assign w_len     = (r_state != SINK_REALIGN_FIRST) ? r_len :
                     (ctrl_i.line_length == 16'd0)   ? 16'd1 : ctrl_i.line_length;

  assign w_lsh        = SH_W'({w_k, 3'b000});
  assign w_rsh        = SH_W'(DATA_WIDTH) - w_lsh;
  assign w_shl        = stream_i.data << w_lsh;
  assign w_shr        = r_prev >> w_rsh;
  assign w_strb_first = {B{1'b1}} << w_k;

  assign w_in_hs = stream_i.valid && stream_o.ready && (r_state != SINK_REALIGN_FLUSH);
  assign w_last  = w_in_hs && (r_word_cnt == w_len - 16'd1);

  always_comb begin
    w_out_data  = stream_i.data;
    w_out_strb  = '1;
    w_out_valid = stream_i.valid;
    w_in_ready  = stream_o.ready;
    w_line_done = 1'b0;
    w_state_d   = r_state;
    if (r_state == SINK_REALIGN_FLUSH) begin
      // Flush beat is dropped if a clear lands while it is pending.
      w_out_data  = w_shr;
      w_out_strb  = ~w_strb_first;
      w_out_valid = !clear_i;
      w_in_ready  = 1'b0;
      if (stream_o.ready && !clear_i) begin
        w_line_done = 1'b1;
        w_state_d   = SINK_REALIGN_FIRST;
      end
    end else begin
      if (w_active) begin
        if (r_state == SINK_REALIGN_FIRST) begin
          w_out_data = w_shl;
          w_out_strb = w_strb_first;
        end else begin
          w_out_data = w_shl | w_shr;
        end
      end
      if (w_last) begin
        w_state_d   = w_active ? SINK_REALIGN_FLUSH : SINK_REALIGN_FIRST;
        w_line_done = !w_active;
      end else if (w_in_hs) begin
        w_state_d = SINK_REALIGN_MIDDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= SINK_REALIGN_FIRST;
      r_word_cnt <= '0;
      r_prev     <= '0;
      r_offs     <= '0;
      r_len      <= '0;
      r_realign  <= 1'b0;
    end else if (clear_i) begin
      r_state    <= SINK_REALIGN_FIRST;
      r_word_cnt <= '0;
      r_prev     <= '0;
      r_offs     <= '0;
      r_len      <= '0;
      r_realign  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_in_hs) begin
        r_prev     <= stream_i.data;
        r_word_cnt <= w_last ? 16'd0 : r_word_cnt + 16'd1;
        if (r_state == SINK_REALIGN_FIRST) begin
          r_offs    <= w_k;
          r_len     <= w_len;
          r_realign <= ctrl_i.realign;
        end
      end
    end
  end

  assign stream_o.data  = w_out_data;
  assign stream_o.strb  = w_out_strb;
  assign stream_o.valid = w_out_valid;
  assign stream_i.ready = w_in_ready;

  assign flags_o.line_done = w_line_done;
  assign flags_o.busy      = (r_state != SINK_REALIGN_FIRST) || (r_word_cnt != 16'd0);

endmodule
